// File: rtl/cpu16_pkg.sv
// Shared 16-bit CPU definitions: register-file geometry and the writeback entry layout.
package cpu16_pkg;

    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 3;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 3'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic                  we;
        logic [DATA_W-1:0]     result;
    } wb_entry_t;

endpackage

// File: rtl/ex_wb_buffer_if.sv
// Execute -> writeback buffer bus: execute push side, register-file pop side, forwarding lookup.
interface ex_wb_buffer_if
    import cpu16_pkg::*;
#(
    parameter int DATA_W = cpu16_pkg::DATA_W,
    parameter int ADDR_W = cpu16_pkg::REG_ADDR_W,
    parameter int DEPTH  = 2
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              flush;
    logic              ex_valid;
    logic              ex_ready;
    logic [ADDR_W-1:0] ex_rd;
    logic              ex_we;
    logic [DATA_W-1:0] ex_result;
    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_rd;
    logic              wb_we;
    logic [DATA_W-1:0] wb_result;
    logic [ADDR_W-1:0] fwd_rs;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic [CNT_W-1:0]  occupancy;

    // Pipeline / register-file side.
    modport master (
        output flush, ex_valid, ex_rd, ex_we, ex_result, wb_ready, fwd_rs,
        input  ex_ready, wb_valid, wb_rd, wb_we, wb_result, fwd_hit, fwd_data, occupancy
    );

    // Buffer side.
    modport slave (
        input  flush, ex_valid, ex_rd, ex_we, ex_result, wb_ready, fwd_rs,
        output ex_ready, wb_valid, wb_rd, wb_we, wb_result, fwd_hit, fwd_data, occupancy
    );

endinterface

// File: rtl/wb_fwd_match.sv
// Youngest-first forwarding search over the buffered writeback entries.
module wb_fwd_match
    import cpu16_pkg::*;
#(
    parameter int DATA_W = cpu16_pkg::DATA_W,
    parameter int ADDR_W = cpu16_pkg::REG_ADDR_W,
    parameter int DEPTH  = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic [PTR_W-1:0]             wr_ptr_i,
    input  logic [CNT_W-1:0]             count_i,
    input  logic [DEPTH-1:0][ADDR_W-1:0] rd_i,
    input  logic [DEPTH-1:0]             we_i,
    input  logic [DEPTH-1:0][DATA_W-1:0] result_i,
    input  logic [ADDR_W-1:0]            rs_i,
    output logic                         hit_o,
    output logic [DATA_W-1:0]            data_o
);

    // Age k = 0 is the youngest entry, sitting just behind the write pointer.
    logic [DEPTH-1:0][PTR_W-1:0] slot;
    logic [DEPTH-1:0]            match;

    genvar k;
    generate
        for (k = 0; k < DEPTH; k++) begin : g_age
            assign slot[k]  = wr_ptr_i - PTR_W'(k + 1);
            assign match[k] = (CNT_W'(k) < count_i) && we_i[slot[k]] && (rd_i[slot[k]] == rs_i);
        end
    endgenerate

    // Scan oldest to youngest so the youngest match overwrites last.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        if (rs_i != ADDR_W'(REG_ZERO)) begin
            for (int a = DEPTH - 1; a >= 0; a--) begin
                if (match[a]) begin
                    hit_o  = 1'b1;
                    data_o = result_i[slot[a]];
                end
            end
        end
    end

endmodule

// File: rtl/ex_wb_buffer.sv
// Execute-to-writeback FIFO: in-order delivery to the register-file port plus operand forwarding.
module ex_wb_buffer
    import cpu16_pkg::*;
#(
    parameter int DATA_W = cpu16_pkg::DATA_W,
    parameter int ADDR_W = cpu16_pkg::REG_ADDR_W,
    parameter int DEPTH  = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    ex_wb_buffer_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [CNT_W-1:0]             count_q, count_d;
    logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0][ADDR_W-1:0] rd_q;
    logic [DEPTH-1:0]             we_q;
    logic [DEPTH-1:0][DATA_W-1:0] res_q;
    logic                         push, pop;

    // Handshake flags depend only on registered count, so ex_ready never sees wb_ready.
    assign bus.ex_ready  = (count_q != CNT_W'(DEPTH));
    assign bus.wb_valid  = (count_q != '0);
    assign bus.occupancy = count_q;

    assign push = bus.ex_valid & bus.ex_ready;
    assign pop  = bus.wb_valid & bus.wb_ready;

    assign bus.wb_rd     = rd_q[rd_ptr_q];
    assign bus.wb_we     = we_q[rd_ptr_q];
    assign bus.wb_result = res_q[rd_ptr_q];

    // Flush overrides any same-cycle push or pop.
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (bus.flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= '0;
            we_q  <= '0;
            res_q <= '0;
        end else if (push && !bus.flush) begin
            rd_q[wr_ptr_q]  <= bus.ex_rd;
            we_q[wr_ptr_q]  <= bus.ex_we;
            res_q[wr_ptr_q] <= bus.ex_result;
        end
    end

    wb_fwd_match #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fwd (
        .wr_ptr_i (wr_ptr_q),
        .count_i  (count_q),
        .rd_i     (rd_q),
        .we_i     (we_q),
        .result_i (res_q),
        .rs_i     (bus.fwd_rs),
        .hit_o    (bus.fwd_hit),
        .data_o   (bus.fwd_data)
    );

endmodule

// File: tb/tb_ex_wb_buffer.sv
// Directed bench for ex_wb_buffer: reset, ordering, backpressure, wrap, forwarding, flush.
module tb_ex_wb_buffer;
    import cpu16_pkg::*;

    logic clk;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    ex_wb_buffer_if #(.DATA_W(16), .ADDR_W(3), .DEPTH(2)) bus ();

    ex_wb_buffer #(.DATA_W(16), .ADDR_W(3), .DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input wb_entry_t e);
        bus.ex_valid  = v;
        bus.ex_rd     = e.rd;
        bus.ex_we     = e.we;
        bus.ex_result = e.result;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.flush = 1'b0;
        bus.wb_ready = 1'b0;
        bus.fwd_rs = 3'd3;
        drive(1'b1, '{rd: 3'd3, we: 1'b1, result: 16'h5A5A});
        for (int c = 0; c < 3; c++) begin
            step();
            n_vec++;
            if ({bus.ex_ready, bus.wb_valid, bus.occupancy, bus.fwd_hit} !== 5'b1_0_00_0) begin
                n_err++;
                $display("FAIL reset_flags got rdy=%b vld=%b occ=%0d hit=%b want 1 0 0 0",
                         bus.ex_ready, bus.wb_valid, bus.occupancy, bus.fwd_hit);
            end
            n_vec++;
            if ({bus.wb_rd, bus.wb_we, bus.wb_result, bus.fwd_data} !== 36'h0) begin
                n_err++;
                $display("FAIL reset_data got rd=%0d we=%b res=%h fwd=%h want 0",
                         bus.wb_rd, bus.wb_we, bus.wb_result, bus.fwd_data);
            end
        end
        drive(1'b0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_vec++;
        if (bus.occupancy !== 2'd0) begin
            n_err++;
            $display("FAIL reset_release_occ got %0d want 0", bus.occupancy);
        end
    endtask

    task automatic test_single();
        bus.wb_ready = 1'b1;
        drive(1'b1, '{rd: 3'd3, we: 1'b1, result: 16'h0001});
        step();
        drive(1'b0, '0);
        n_vec++;
        if ({bus.wb_valid, bus.wb_rd, bus.wb_we, bus.wb_result, bus.occupancy} !==
            {1'b1, 3'd3, 1'b1, 16'h0001, 2'd1}) begin
            n_err++;
            $display("FAIL single_head got vld=%b rd=%0d we=%b res=%h occ=%0d want 1 3 1 0001 1",
                     bus.wb_valid, bus.wb_rd, bus.wb_we, bus.wb_result, bus.occupancy);
        end
        step();
        n_vec++;
        if ({bus.wb_valid, bus.occupancy} !== 3'b0_00) begin
            n_err++;
            $display("FAIL single_drain got vld=%b occ=%0d want 0 0", bus.wb_valid, bus.occupancy);
        end
    endtask

    task automatic test_fill();
        bus.wb_ready = 1'b0;
        drive(1'b1, '{rd: 3'd1, we: 1'b1, result: 16'hAAAA});
        step();
        drive(1'b1, '{rd: 3'd2, we: 1'b1, result: 16'h5555});
        step();
        n_vec++;
        if ({bus.occupancy, bus.ex_ready, bus.wb_result} !== {2'd2, 1'b0, 16'hAAAA}) begin
            n_err++;
            $display("FAIL fill_full got occ=%0d rdy=%b head=%h want 2 0 AAAA",
                     bus.occupancy, bus.ex_ready, bus.wb_result);
        end
        drive(1'b1, '{rd: 3'd4, we: 1'b1, result: 16'h1234});
        step();
        n_vec++;
        if ({bus.occupancy, bus.wb_result} !== {2'd2, 16'hAAAA}) begin
            n_err++;
            $display("FAIL fill_reject got occ=%0d head=%h want 2 AAAA", bus.occupancy, bus.wb_result);
        end
        // Pop while full with an offer pending: the offer must wait a cycle.
        bus.wb_ready = 1'b1;
        step();
        n_vec++;
        if ({bus.occupancy, bus.wb_rd, bus.wb_result} !== {2'd1, 3'd2, 16'h5555}) begin
            n_err++;
            $display("FAIL fill_pop1 got occ=%0d rd=%0d head=%h want 1 2 5555",
                     bus.occupancy, bus.wb_rd, bus.wb_result);
        end
        step();
        drive(1'b0, '0);
        n_vec++;
        if ({bus.occupancy, bus.wb_rd, bus.wb_result} !== {2'd1, 3'd4, 16'h1234}) begin
            n_err++;
            $display("FAIL fill_pop2 got occ=%0d rd=%0d head=%h want 1 4 1234",
                     bus.occupancy, bus.wb_rd, bus.wb_result);
        end
        step();
        n_vec++;
        if (bus.occupancy !== 2'd0) begin
            n_err++;
            $display("FAIL fill_drain got occ=%0d want 0", bus.occupancy);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d;
        logic [15:0] exp_head;
        bus.wb_ready = 1'b0;
        drive(1'b1, '{rd: 3'd5, we: 1'b1, result: 16'h0100});
        step();
        bus.wb_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            d        = 16'(16'h0101 + i);
            exp_head = 16'(16'h0100 + i);
            drive(1'b1, '{rd: 3'd5, we: 1'b1, result: d});
            n_vec++;
            if (bus.wb_result !== exp_head) begin
                n_err++;
                $display("FAIL b2b_head[%0d] got %h want %h", i, bus.wb_result, exp_head);
            end
            step();
            n_vec++;
            if (bus.occupancy !== 2'd1) begin
                n_err++;
                $display("FAIL b2b_occ[%0d] got %0d want 1", i, bus.occupancy);
            end
        end
        drive(1'b0, '0);
        n_vec++;
        if (bus.wb_result !== 16'h010A) begin
            n_err++;
            $display("FAIL b2b_last got %h want 010A", bus.wb_result);
        end
        step();
        n_vec++;
        if (bus.occupancy !== 2'd0) begin
            n_err++;
            $display("FAIL b2b_drain got occ=%0d want 0", bus.occupancy);
        end
    endtask

    task automatic test_forward();
        bus.wb_ready = 1'b0;
        drive(1'b1, '{rd: 3'd2, we: 1'b1, result: 16'h0010});
        step();
        drive(1'b1, '{rd: 3'd2, we: 1'b1, result: 16'h0020});
        step();
        drive(1'b1, '{rd: 3'd5, we: 1'b1, result: 16'h0099});
        bus.fwd_rs = 3'd2;
        #1;
        n_vec++;
        if ({bus.fwd_hit, bus.fwd_data} !== {1'b1, 16'h0020}) begin
            n_err++;
            $display("FAIL fwd_youngest got hit=%b data=%h want 1 0020", bus.fwd_hit, bus.fwd_data);
        end
        bus.fwd_rs = 3'd0;
        #1;
        n_vec++;
        if ({bus.fwd_hit, bus.fwd_data} !== 17'h0) begin
            n_err++;
            $display("FAIL fwd_r0 got hit=%b data=%h want 0 0000", bus.fwd_hit, bus.fwd_data);
        end
        bus.fwd_rs = 3'd5;
        #1;
        n_vec++;
        if ({bus.fwd_hit, bus.fwd_data} !== 17'h0) begin
            n_err++;
            $display("FAIL fwd_miss got hit=%b data=%h want 0 0000", bus.fwd_hit, bus.fwd_data);
        end
        drive(1'b0, '0);
        bus.wb_ready = 1'b1;
        step();
        step();
        // Younger we=0 entry must be skipped in favour of the older we=1 entry.
        bus.wb_ready = 1'b0;
        drive(1'b1, '{rd: 3'd2, we: 1'b1, result: 16'h0030});
        step();
        drive(1'b1, '{rd: 3'd2, we: 1'b0, result: 16'h0040});
        step();
        drive(1'b0, '0);
        bus.fwd_rs = 3'd2;
        #1;
        n_vec++;
        if ({bus.fwd_hit, bus.fwd_data} !== {1'b1, 16'h0030}) begin
            n_err++;
            $display("FAIL fwd_skip_we0 got hit=%b data=%h want 1 0030", bus.fwd_hit, bus.fwd_data);
        end
        bus.wb_ready = 1'b1;
        step();
        bus.wb_ready = 1'b0;
        n_vec++;
        if ({bus.fwd_hit, bus.fwd_data, bus.wb_we, bus.wb_result, bus.occupancy} !==
            {1'b0, 16'h0000, 1'b0, 16'h0040, 2'd1}) begin
            n_err++;
            $display("FAIL fwd_we0_only got hit=%b data=%h we=%b head=%h occ=%0d want 0 0000 0 0040 1",
                     bus.fwd_hit, bus.fwd_data, bus.wb_we, bus.wb_result, bus.occupancy);
        end
        bus.wb_ready = 1'b1;
        step();
        // r0 writes are queued but never forwarded.
        bus.wb_ready = 1'b0;
        drive(1'b1, '{rd: 3'd0, we: 1'b1, result: 16'hFFFF});
        step();
        drive(1'b0, '0);
        bus.fwd_rs = 3'd0;
        #1;
        n_vec++;
        if ({bus.wb_valid, bus.wb_rd, bus.wb_we, bus.wb_result, bus.fwd_hit} !==
            {1'b1, 3'd0, 1'b1, 16'hFFFF, 1'b0}) begin
            n_err++;
            $display("FAIL fwd_r0_entry got vld=%b rd=%0d we=%b head=%h hit=%b want 1 0 1 FFFF 0",
                     bus.wb_valid, bus.wb_rd, bus.wb_we, bus.wb_result, bus.fwd_hit);
        end
        bus.wb_ready = 1'b1;
        step();
        bus.wb_ready = 1'b0;
    endtask

    task automatic test_flush();
        bus.wb_ready = 1'b0;
        drive(1'b1, '{rd: 3'd1, we: 1'b1, result: 16'hBEEF});
        step();
        // Flush at occupancy 1 with both a push and a pop offered.
        bus.flush = 1'b1;
        bus.wb_ready = 1'b1;
        drive(1'b1, '{rd: 3'd2, we: 1'b1, result: 16'hCAFE});
        step();
        bus.flush = 1'b0;
        bus.wb_ready = 1'b0;
        drive(1'b0, '0);
        n_vec++;
        if ({bus.occupancy, bus.wb_valid} !== 3'b00_0) begin
            n_err++;
            $display("FAIL flush_occ1 got occ=%0d vld=%b want 0 0", bus.occupancy, bus.wb_valid);
        end
        drive(1'b1, '{rd: 3'd6, we: 1'b1, result: 16'h7777});
        step();
        drive(1'b1, '{rd: 3'd1, we: 1'b1, result: 16'h1111});
        n_vec++;
        if ({bus.occupancy, bus.wb_rd, bus.wb_result} !== {2'd1, 3'd6, 16'h7777}) begin
            n_err++;
            $display("FAIL flush_refill got occ=%0d rd=%0d head=%h want 1 6 7777",
                     bus.occupancy, bus.wb_rd, bus.wb_result);
        end
        step();
        // Flush at occupancy 2 with a push offered.
        bus.flush = 1'b1;
        drive(1'b1, '{rd: 3'd3, we: 1'b1, result: 16'h2222});
        n_vec++;
        if (bus.occupancy !== 2'd2) begin
            n_err++;
            $display("FAIL flush_pre got occ=%0d want 2", bus.occupancy);
        end
        step();
        bus.flush = 1'b0;
        drive(1'b0, '0);
        n_vec++;
        if ({bus.occupancy, bus.wb_valid, bus.ex_ready} !== 4'b00_0_1) begin
            n_err++;
            $display("FAIL flush_occ2 got occ=%0d vld=%b rdy=%b want 0 0 1",
                     bus.occupancy, bus.wb_valid, bus.ex_ready);
        end
        step();
        n_vec++;
        if ({bus.occupancy, bus.wb_valid} !== 3'b00_0) begin
            n_err++;
            $display("FAIL flush_stays_empty got occ=%0d vld=%b want 0 0", bus.occupancy, bus.wb_valid);
        end
    endtask

    task automatic test_async_reset();
        bus.wb_ready = 1'b0;
        drive(1'b1, '{rd: 3'd7, we: 1'b1, result: 16'h4242});
        step();
        drive(1'b0, '0);
        n_vec++;
        if (bus.occupancy !== 2'd1) begin
            n_err++;
            $display("FAIL areset_pre got occ=%0d want 1", bus.occupancy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.occupancy, bus.wb_valid, bus.wb_result, bus.wb_rd} !== 22'h0) begin
            n_err++;
            $display("FAIL areset_now got occ=%0d vld=%b head=%h rd=%0d want 0 0 0000 0",
                     bus.occupancy, bus.wb_valid, bus.wb_result, bus.wb_rd);
        end
        #2 rst_n = 1'b1;
        step();
        n_vec++;
        if (bus.occupancy !== 2'd0) begin
            n_err++;
            $display("FAIL areset_after got occ=%0d want 0", bus.occupancy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_forward();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
